// File: rtl/cnt_share_sched_if.sv
// rtl/cnt_share_sched_if.sv - request/grant and counter-control bundle for cnt_share_sched
interface cnt_share_sched_if #(
  parameter int CWID = 8,
  parameter int NREQ = 4
);
  logic [NREQ-1:0] req;
  logic [CWID-1:0] len_m1;
  logic            hold;
  logic [NREQ-1:0] gnt;
  logic            cnt_clr;
  logic            cnt_en;
  logic            bit_vld;
  logic            done;
  logic            busy;

  modport master (
    output req, len_m1, hold,
    input  gnt, cnt_clr, cnt_en, bit_vld, done, busy
  );

  modport slave (
    input  req, len_m1, hold,
    output gnt, cnt_clr, cnt_en, bit_vld, done, busy
  );
endinterface

// File: rtl/cnt_share_sched.sv
// rtl/cnt_share_sched.sv - shared counter arbiter/window sequencer; CNT_SHARE_SCHED_RR_EN selects round-robin
// Without CNT_SHARE_SCHED_RR_EN the lowest requesting index always wins.
module cnt_share_sched #(
  parameter int CWID = 8,
  parameter int NREQ = 4,
  parameter int WLAT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  cnt_share_sched_if.slave bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int DW = (WLAT > 1) ? $clog2(WLAT) : 1;

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;

  state_t          state, state_nx;
  logic [CWID-1:0] pos, len_q;
  logic [DW-1:0]   dcnt;
  logic [NREQ-1:0] gnt_q, win_oh;
  logic [WLAT-1:0] vld_sr;
  logic [IW-1:0]   win_idx;
  logic            win_found;
  logic            cnt_en, cnt_clr;

`ifdef CNT_SHARE_SCHED_RR_EN
  logic [IW-1:0] rr_ptr;

  // Search starts at rr_ptr, which already points one past the previous winner.
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(rr_ptr) + i) % NREQ;
      if (!win_found && bus.req[IW'(idx)]) begin
        win_found = 1'b1;
        win_idx   = IW'(idx);
      end
    end
  end
`else
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!win_found && bus.req[IW'(i)]) begin
        win_found = 1'b1;
        win_idx   = IW'(i);
      end
    end
  end
`endif

  assign win_oh = win_found ? (NREQ'(1) << win_idx) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    cnt_en   = 1'b0;
    cnt_clr  = 1'b0;
    case (state)
      IDLE:  if (win_found) state_nx = CLEAR;
      CLEAR: begin
        cnt_clr  = 1'b1;
        state_nx = RUN;
      end
      RUN: begin
        cnt_en = ~bus.hold;
        if (cnt_en && pos == len_q) state_nx = DRAIN;
      end
      DRAIN: if (dcnt == DW'(WLAT - 1)) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q  <= '0;
      len_q  <= '0;
      pos    <= '0;
      dcnt   <= '0;
`ifdef CNT_SHARE_SCHED_RR_EN
      rr_ptr <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (win_found) begin
          gnt_q  <= win_oh;
          len_q  <= bus.len_m1;
          pos    <= '0;
`ifdef CNT_SHARE_SCHED_RR_EN
          rr_ptr <= (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
`endif
        end
        RUN: begin
          // Hold at len_q on the last beat so pos never wraps for a full-range window.
          if (cnt_en && pos != len_q) pos <= pos + 1'b1;
          dcnt <= '0;
        end
        DRAIN: dcnt <= dcnt + 1'b1;
        DONE:  gnt_q <= '0;
        default: ;
      endcase
    end
  end

  // Valid pipeline tracks the counter/buffer latency; only reset clears it.
  generate
    if (WLAT == 1) begin : g_vld1
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_sr <= '0;
        else        vld_sr <= cnt_en;
      end
    end else begin : g_vldn
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_sr <= '0;
        else        vld_sr <= {vld_sr[WLAT-2:0], cnt_en};
      end
    end
  endgenerate

  assign bus.gnt     = gnt_q;
  assign bus.cnt_clr = cnt_clr;
  assign bus.cnt_en  = cnt_en;
  assign bus.bit_vld = vld_sr[WLAT-1];
  assign bus.done    = (state == DONE);
  assign bus.busy    = (state != IDLE);
endmodule

// File: tb/tb_cnt_share_sched.sv
// tb/tb_cnt_share_sched.sv - scoreboard bench for cnt_share_sched windows, timing and arbitration
module tb_cnt_share_sched;
  localparam int CWID = 8;
  localparam int NREQ = 4;
  localparam int WLAT = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cnt_share_sched_if #(.CWID(CWID), .NREQ(NREQ)) bus();
  cnt_share_sched #(.CWID(CWID), .NREQ(NREQ), .WLAT(WLAT)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic [3:0] gnt;
    int en;
    int vld;
    int clr;
    int lat;
    int start;
  } win_t;

  win_t exp_q[$];
  win_t obs_q[$];
  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;

  logic [63:0] tr_gnt, tr_clr, tr_en, tr_vld, tr_done, tr_busy;
  logic [63:0] e_gnt, e_clr, e_en, e_vld, e_done;

  always @(posedge clk) cyc <= cyc + 1;

  // Window monitor: one record per completed window, from gnt rise to done.
  initial begin
    bit in_win;
    logic [3:0] prev_gnt;
    win_t m;
    in_win = 0;
    prev_gnt = '0;
    m = '{gnt: '0, en: 0, vld: 0, clr: 0, lat: 0, start: 0};
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        in_win = 0;
        prev_gnt = '0;
      end else begin
        if (bus.gnt != 0 && prev_gnt == 0) begin
          in_win = 1;
          m.en = 0; m.vld = 0; m.clr = 0; m.start = cyc;
        end
        if (in_win) begin
          m.en  += int'(bus.cnt_en);
          m.vld += int'(bus.bit_vld);
          m.clr += int'(bus.cnt_clr);
          if (bus.done) begin
            m.gnt = bus.gnt;
            m.lat = cyc - m.start;
            obs_q.push_back(m);
            in_win = 0;
          end
        end
        prev_gnt = bus.gnt;
      end
    end
  end

  function automatic void model(input int L, input logic [63:0] hm);
    int k, cnt, d;
    e_gnt = '0; e_clr = '0; e_en = '0; e_vld = '0; e_done = '0;
    e_clr[1] = 1'b1;
    k = 2; cnt = 0;
    while (cnt <= L && k < 56) begin
      if (!hm[k]) begin
        e_en[k] = 1'b1;
        cnt++;
      end
      k++;
    end
    for (int j = 0; j < 64 - WLAT; j++) e_vld[j + WLAT] = e_en[j];
    d = k + WLAT;
    e_done[d] = 1'b1;
    for (int j = 1; j <= d; j++) e_gnt[j] = 1'b1;
  endfunction

  task automatic run_trace(input int L, input logic [63:0] hm, input int ncyc);
    tr_gnt = '0; tr_clr = '0; tr_en = '0; tr_vld = '0; tr_done = '0; tr_busy = '0;
    @(posedge clk); #1;
    bus.len_m1 = CWID'(L);
    bus.hold = 1'b0;
    bus.req = 4'b0001;
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge clk); #1;
      bus.hold = hm[k];
      bus.len_m1 = 8'hA5;
      @(negedge clk);
      tr_gnt[k]  = (bus.gnt == 4'b0001);
      tr_clr[k]  = bus.cnt_clr;
      tr_en[k]   = bus.cnt_en;
      tr_vld[k]  = bus.bit_vld;
      tr_done[k] = bus.done;
      tr_busy[k] = bus.busy;
      if (bus.done) bus.req = '0;
    end
    bus.hold = 1'b0;
  endtask

  task automatic run_windows(input int n, input int budget, output bit ok);
    int cnt;
    cnt = 0;
    for (int c = 0; c < budget && cnt < n; c++) begin
      @(negedge clk);
      if (bus.done) begin
        cnt++;
        if (cnt == n) bus.req = '0;
      end
    end
    ok = (cnt == n);
  endtask

  task automatic pop_obs(output win_t o, output bit ok);
    for (int c = 0; c < 20 && obs_q.size() == 0; c++) @(negedge clk);
    ok = (obs_q.size() > 0);
    o = '{gnt: 'x, en: -1, vld: -1, clr: -1, lat: -1, start: -1};
    if (ok) o = obs_q.pop_front();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req = '0; bus.len_m1 = '0; bus.hold = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (bus.gnt !== 4'b0000) $display("FAIL reset_gnt: got %b want 0000", bus.gnt); else n_pass++;
    n_checks++; if (bus.cnt_clr !== 1'b0) $display("FAIL reset_clr: got %b want 0", bus.cnt_clr); else n_pass++;
    n_checks++; if (bus.cnt_en !== 1'b0) $display("FAIL reset_en: got %b want 0", bus.cnt_en); else n_pass++;
    n_checks++; if (bus.bit_vld !== 1'b0) $display("FAIL reset_vld: got %b want 0", bus.bit_vld); else n_pass++;
    n_checks++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    win_t o, e;
    bit ok;
    exp_q.push_back('{gnt: 4'b0001, en: 4, vld: 4, clr: 1, lat: 3 + 2 + WLAT, start: 0});
    model(3, 64'd0);
    run_trace(3, 64'd0, 10);
    n_checks++; if (tr_gnt !== e_gnt) $display("FAIL single_gnt: got %h want %h", tr_gnt, e_gnt); else n_pass++;
    n_checks++; if (tr_clr !== e_clr) $display("FAIL single_clr: got %h want %h", tr_clr, e_clr); else n_pass++;
    n_checks++; if (tr_en !== e_en) $display("FAIL single_en: got %h want %h", tr_en, e_en); else n_pass++;
    n_checks++; if (tr_vld !== e_vld) $display("FAIL single_vld: got %h want %h", tr_vld, e_vld); else n_pass++;
    n_checks++; if (tr_done !== e_done) $display("FAIL single_done: got %h want %h", tr_done, e_done); else n_pass++;
    n_checks++; if (tr_busy !== e_gnt) $display("FAIL single_busy: got %h want %h", tr_busy, e_gnt); else n_pass++;
    pop_obs(o, ok);
    e = exp_q.pop_front();
    n_checks++;
    if (!ok || o.gnt !== e.gnt || o.en != e.en || o.vld != e.vld || o.clr != e.clr || o.lat != e.lat)
      $display("FAIL sb_single: got gnt=%b en=%0d vld=%0d clr=%0d lat=%0d want gnt=%b en=%0d vld=%0d clr=%0d lat=%0d",
               o.gnt, o.en, o.vld, o.clr, o.lat, e.gnt, e.en, e.vld, e.clr, e.lat);
    else n_pass++;
  endtask

  task automatic test_hold();
    win_t o, e;
    bit ok;
    logic [63:0] hm;
    hm = '0;
    hm[3] = 1'b1; hm[4] = 1'b1; hm[8] = 1'b1; hm[9] = 1'b1;
    exp_q.push_back('{gnt: 4'b0001, en: 4, vld: 4, clr: 1, lat: 3 + 2 + WLAT + 2, start: 0});
    model(3, hm);
    run_trace(3, hm, 14);
    n_checks++; if (tr_en !== e_en) $display("FAIL hold_en: got %h want %h", tr_en, e_en); else n_pass++;
    n_checks++; if (tr_vld !== e_vld) $display("FAIL hold_vld: got %h want %h", tr_vld, e_vld); else n_pass++;
    n_checks++; if (tr_done !== e_done) $display("FAIL hold_done: got %h want %h", tr_done, e_done); else n_pass++;
    pop_obs(o, ok);
    e = exp_q.pop_front();
    n_checks++;
    if (!ok || o.gnt !== e.gnt || o.en != e.en || o.vld != e.vld || o.lat != e.lat)
      $display("FAIL sb_hold: got gnt=%b en=%0d vld=%0d lat=%0d want gnt=%b en=%0d vld=%0d lat=%0d",
               o.gnt, o.en, o.vld, o.lat, e.gnt, e.en, e.vld, e.lat);
    else n_pass++;
  endtask

  task automatic test_len_min();
    win_t o, e;
    bit ok;
    exp_q.push_back('{gnt: 4'b0001, en: 1, vld: 1, clr: 1, lat: 0 + 2 + WLAT, start: 0});
    model(0, 64'd0);
    run_trace(0, 64'd0, 8);
    n_checks++; if (tr_en !== e_en) $display("FAIL len0_en: got %h want %h", tr_en, e_en); else n_pass++;
    n_checks++; if (tr_vld !== e_vld) $display("FAIL len0_vld: got %h want %h", tr_vld, e_vld); else n_pass++;
    n_checks++; if (tr_done !== e_done) $display("FAIL len0_done: got %h want %h", tr_done, e_done); else n_pass++;
    pop_obs(o, ok);
    e = exp_q.pop_front();
    n_checks++;
    if (!ok || o.en != e.en || o.vld != e.vld || o.lat != e.lat)
      $display("FAIL sb_len0: got en=%0d vld=%0d lat=%0d want en=%0d vld=%0d lat=%0d",
               o.en, o.vld, o.lat, e.en, e.vld, e.lat);
    else n_pass++;
  endtask

  task automatic test_len_max();
    win_t o, e;
    bit ok, run_ok;
    @(posedge clk); #1;
    bus.len_m1 = 8'd255;
    bus.hold = 1'b0;
    bus.req = 4'b0001;
    exp_q.push_back('{gnt: 4'b0001, en: 256, vld: 256, clr: 1, lat: 255 + 2 + WLAT, start: 0});
    run_windows(1, 400, run_ok);
    pop_obs(o, ok);
    e = exp_q.pop_front();
    n_checks++;
    if (!run_ok || !ok || o.gnt !== e.gnt || o.en != e.en || o.vld != e.vld || o.lat != e.lat)
      $display("FAIL sb_lenmax: done_seen=%0d got gnt=%b en=%0d vld=%0d lat=%0d want gnt=%b en=%0d vld=%0d lat=%0d",
               run_ok, o.gnt, o.en, o.vld, o.lat, e.gnt, e.en, e.vld, e.lat);
    else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    win_t o, e;
    bit ok, run_ok;
    @(posedge clk); #1;
    bus.len_m1 = 8'd7;
    bus.hold = 1'b0;
    bus.req = 4'b0001;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.gnt !== 4'b0000) $display("FAIL midrst_gnt: got %b want 0000", bus.gnt); else n_pass++;
    n_checks++;
    if ({bus.cnt_clr, bus.cnt_en, bus.bit_vld, bus.done, bus.busy} !== 5'b00000)
      $display("FAIL midrst_ctl: got clr/en/vld/done/busy=%b want 00000",
               {bus.cnt_clr, bus.cnt_en, bus.bit_vld, bus.done, bus.busy});
    else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++; if (obs_q.size() != 0) $display("FAIL midrst_nodone: got %0d windows want 0", obs_q.size()); else n_pass++;
    rst_n = 1'b1;
    exp_q.push_back('{gnt: 4'b0001, en: 8, vld: 8, clr: 1, lat: 7 + 2 + WLAT, start: 0});
    run_windows(1, 60, run_ok);
    pop_obs(o, ok);
    e = exp_q.pop_front();
    n_checks++;
    if (!run_ok || !ok || o.gnt !== e.gnt || o.en != e.en || o.vld != e.vld || o.clr != e.clr || o.lat != e.lat)
      $display("FAIL sb_midrst: got gnt=%b en=%0d vld=%0d clr=%0d lat=%0d want gnt=%b en=%0d vld=%0d clr=%0d lat=%0d",
               o.gnt, o.en, o.vld, o.clr, o.lat, e.gnt, e.en, e.vld, e.clr, e.lat);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    win_t o, e;
    bit ok, run_ok;
    int nwin, prev_start;
    rst_n = 1'b0;
    bus.req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    bus.len_m1 = 8'd1;
    bus.hold = 1'b0;
`ifdef CNT_SHARE_SCHED_RR_EN
    nwin = 5;
    bus.req = 4'b1111;
    exp_q.push_back('{gnt: 4'b0001, en: 2, vld: 2, clr: 1, lat: 1 + 2 + WLAT, start: 0});
    exp_q.push_back('{gnt: 4'b0010, en: 2, vld: 2, clr: 1, lat: 1 + 2 + WLAT, start: 0});
    exp_q.push_back('{gnt: 4'b0100, en: 2, vld: 2, clr: 1, lat: 1 + 2 + WLAT, start: 0});
    exp_q.push_back('{gnt: 4'b1000, en: 2, vld: 2, clr: 1, lat: 1 + 2 + WLAT, start: 0});
    exp_q.push_back('{gnt: 4'b0001, en: 2, vld: 2, clr: 1, lat: 1 + 2 + WLAT, start: 0});
`else
    nwin = 4;
    bus.req = 4'b1010;
    for (int i = 0; i < nwin; i++)
      exp_q.push_back('{gnt: 4'b0010, en: 2, vld: 2, clr: 1, lat: 1 + 2 + WLAT, start: 0});
`endif
    run_windows(nwin, 200, run_ok);
    n_checks++; if (!run_ok) $display("FAIL arb_timeout: got fewer than %0d windows", nwin); else n_pass++;
    prev_start = -1;
    for (int i = 0; i < nwin; i++) begin
      pop_obs(o, ok);
      e = exp_q.pop_front();
      n_checks++;
      if (!ok || o.gnt !== e.gnt || o.en != e.en || o.vld != e.vld || o.lat != e.lat)
        $display("FAIL sb_arb%0d: got gnt=%b en=%0d vld=%0d lat=%0d want gnt=%b en=%0d vld=%0d lat=%0d",
                 i, o.gnt, o.en, o.vld, o.lat, e.gnt, e.en, e.vld, e.lat);
      else n_pass++;
      if (ok && prev_start >= 0) begin
        n_checks++;
        if (o.start - prev_start != 1 + 4 + WLAT)
          $display("FAIL arb_gap%0d: got %0d cycles want %0d", i, o.start - prev_start, 1 + 4 + WLAT);
        else n_pass++;
      end
      if (ok) prev_start = o.start;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_hold();
    test_len_min();
    test_len_max();
    test_reset_mid_run();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/cnt_share_sched.md
# cnt_share_sched

Sequencer and arbiter for the shared stochastic-computing counter array. It grants the single shared counter to one of `NREQ` requesters at a time and runs one bitstream window of programmable length. It drives the counter's enable and clear, and produces a consumer-side valid aligned to the counter-array pipeline. It signals completion per window and sits between the uBrain layer controllers and the shared counter/buffer array.

## Interface
- `CWID`, 8, counter width; window length is up to 2^CWID cycles
- `NREQ`, 4, number of requesters
- `WLAT`, 2, cycles from `cnt_en` to counter value valid at consumers (counter register + buffer stage); `WLAT` ≥ 1

- `clk`  in  1  single clock; all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req`  in  NREQ  level request per requester; held until its `done`
- `len_m1`  in  CWID  window length minus one; sampled on grant
- `hold`  in  1  consumer backpressure; freezes the window in RUN
- `gnt`  out  NREQ  one-hot owner, held from grant through `done`
- `cnt_clr`  out  1  one-cycle synchronous clear to the shared counter
- `cnt_en`  out  1  enable to the shared counter
- `bit_vld`  out  1  `cnt_en` delayed `WLAT` cycles; consumer sample strobe
- `done`  out  1  one-cycle pulse at window end, coincident with `gnt`
- `busy`  out  1  high in every state except IDLE

## Operation
- FSM has five states: IDLE, CLEAR, RUN, DRAIN, DONE.
- IDLE
  - If `|req`, pick a winner, register one-hot `gnt`, latch `len_m1` into `len_q`, zero `pos`, and go to CLEAR.
  - Otherwise stay in IDLE.
- CLEAR: `cnt_clr`=1 for exactly one cycle, then go to RUN.
- RUN
  - `cnt_en` = ~`hold`. `pos` (CWID bits) increments when `cnt_en`=1.
  - When `cnt_en`=1 and `pos`==`len_q`, go to DRAIN. `pos` never wraps.
- DRAIN
  - `cnt_en`=0 for `WLAT` cycles while the valid shift register empties.
  - `hold` is ignored. Then go to DONE.
- DONE: `done`=1 for one cycle with `gnt` still valid, then clear `gnt` and go to IDLE.
- Arbitration
  - Round-robin search starts at the index after the last winner.
  - `rr_ptr` updates on grant only.
- Requests are sampled only in IDLE.
  - Dropping `req` mid-window does not abort the window.
  - `len_m1` changes after the grant are ignored.
- `bit_vld` is a `WLAT`-deep shift register of `cnt_en`. It is cleared on reset only, never by `cnt_clr`.
- `len_m1`=0 gives a one-cycle window. `len_m1`=2^CWID−1 gives a full 2^CWID-cycle window.

## Timing
- Reset values: `gnt`=0, `cnt_clr`=0, `cnt_en`=0, `bit_vld`=0, `done`=0, `busy`=0, state IDLE, `pos`=0, `len_q`=0, `rr_ptr`=0 (requester 0 highest priority first).
- Reset asserted at any point, including mid-RUN, returns everything to reset values immediately. No `done` is issued for the aborted window.
- With `req` seen in IDLE at cycle t, `len_m1`=L and no `hold`:
  - `gnt` and `cnt_clr` at t+1.
  - `cnt_en` from t+2 to t+2+L.
  - `bit_vld` from t+2+WLAT to t+2+L+WLAT.
  - DRAIN from t+3+L to t+2+L+WLAT.
  - `done` at t+3+L+WLAT.
  - Back in IDLE at t+4+L+WLAT.
  - Earliest next `gnt` at t+5+L+WLAT.
- Each `hold` cycle in RUN extends the window by exactly one cycle. `bit_vld` mirrors the gap `WLAT` cycles later.
- Exactly L+1 `cnt_en` cycles and L+1 `bit_vld` cycles occur per window.

## Configuration
- `CNT_SHARE_SCHED_RR_EN` defined: round-robin arbitration with `rr_ptr` as described.
- Not defined: fixed priority, lowest index wins. `rr_ptr` is not implemented. All other behaviour is identical.

## Test plan
- Single requester: `req`=4'b0001, `len_m1`=3, `WLAT`=2 → `gnt`=0001 one cycle later, `cnt_clr` 1 cycle, 4 `cnt_en` cycles, 4 `bit_vld` cycles lagging 2, `done` 1 cycle at t+8, `busy` low from t+9.
- Fairness (RR_EN): `req`=4'b1111 held → grant order 0,1,2,3,0; no requester granted twice before all others.
- Fixed priority (no RR_EN): `req`=4'b1010 held → requester 1 granted every window; requester 3 starved.
- Backpressure: `len_m1`=3 with `hold`=1 for 2 cycles mid-RUN → 4 `cnt_en` cycles spread over 6; `done` delayed exactly 2 cycles; `hold` during DRAIN has no effect.
- Boundaries: `len_m1`=0 gives exactly one `cnt_en` and one `bit_vld` cycle. `len_m1`=255 (CWID=8) gives 256 `cnt_en` cycles with `pos` not wrapping.
- Reset mid-RUN: `rst_n` low at RUN cycle 5 → all outputs 0 asynchronously, no `done`; after release with `req` still high → fresh grant, full-length window.
